i2c_line_conditioner: RTL



---
 rtl/i2c_line_conditioner.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/i2c_line_conditioner.sv
// i2c_line_conditioner: conditions the raw SCL/SDA pad levels for one open-drain I2C bus.
// It synchronises each line and filters out glitches. From the filtered levels it
// detects START/STOP, tracks bus-busy and flags a bus held low too long.
module i2c_line_conditioner #(
  parameter int unsigned FILTER_LEN    = 4,
  parameter int unsigned STUCK_TIMEOUT = 125000
) (
  input  logic clk,
  input  logic reset,
  input  logic scl_pad_i,
  input  logic sda_pad_i,
  input  logic stuck_clr_i,
  output logic scl_o,
  output logic sda_o,
  output logic start_o,
  output logic stop_o,
  output logic busy_o,
  output logic stuck_o
);

  localparam int unsigned FCW = 4;
  localparam int unsigned SCW = 24;
  localparam int unsigned SCL = 0;
  localparam int unsigned SDA = 1;

  localparam logic [FCW-1:0] FILT_LAST  = FCW'(FILTER_LEN - 1);
  localparam logic [SCW-1:0] STUCK_MAX  = SCW'(STUCK_TIMEOUT);
  localparam logic [SCW-1:0] STUCK_LAST = SCW'(STUCK_TIMEOUT - 1);

  // Index 0 is SCL and index 1 is SDA throughout.
  logic [1:0]     sync1;
  logic [1:0]     sync2;
  logic [1:0]     filt;
  logic [FCW-1:0] fcnt [2];
  logic           scl_q;
  logic           sda_q;
  logic [SCW-1:0] cnt_scl;
  logic [SCW-1:0] cnt_sda;

  logic start_c;
  logic stop_c;
  logic scl_low_c;
  logic sda_low_c;
  logic hit_c;
  logic stuck_rise_c;

  assign scl_o = filt[SCL];
  assign sda_o = filt[SDA];

  // Two-flop synchroniser per line; idles high like the bus.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 2'b11;
      sync2 <= 2'b11;
    end else begin
      sync1 <= {sda_pad_i, scl_pad_i};
      sync2 <= sync1;
    end
  end

  // Stability filter: a new level must hold FILTER_LEN synchronised cycles to be accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt    <= 2'b11;
      fcnt[0] <= '0;
      fcnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FILT_LAST) begin
          filt[i] <= sync2[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + FCW'(1);
        end
      end
    end
  end

  // Event and stuck qualifiers decoded from the filtered lines and their delayed copies.
  always_comb begin
    start_c      = sda_q & ~sda_o & scl_q & scl_o;
    stop_c       = ~sda_q & sda_o & scl_q & scl_o;
    scl_low_c    = ~scl_o;
    sda_low_c    = ~sda_o & scl_o;
    hit_c        = (scl_low_c && (cnt_scl == STUCK_LAST)) ||
                   (sda_low_c && (cnt_sda == STUCK_LAST));
    stuck_rise_c = hit_c & ~stuck_o & ~stuck_clr_i;
  end

  // Delayed filtered levels, event pulses and bus ownership.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_q   <= 1'b1;
      sda_q   <= 1'b1;
      start_o <= 1'b0;
      stop_o  <= 1'b0;
      busy_o  <= 1'b0;
    end else begin
      scl_q   <= scl_o;
      sda_q   <= sda_o;
      start_o <= start_c;
      stop_o  <= stop_c;
      if (stuck_rise_c) begin
        busy_o <= 1'b0;
      end else if (start_c) begin
        busy_o <= 1'b1;
      end else if (stop_c) begin
        busy_o <= 1'b0;
      end
    end
  end

  // Saturating low-time counters and the sticky stuck flag; clear wins over set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_scl <= '0;
      cnt_sda <= '0;
      stuck_o <= 1'b0;
    end else if (stuck_clr_i) begin
      cnt_scl <= '0;
      cnt_sda <= '0;
      stuck_o <= 1'b0;
    end else begin
      if (!scl_low_c) begin
        cnt_scl <= '0;
      end else if (cnt_scl != STUCK_MAX) begin
        cnt_scl <= cnt_scl + SCW'(1);
      end
      if (!sda_low_c) begin
        cnt_sda <= '0;
      end else if (cnt_sda != STUCK_MAX) begin
        cnt_sda <= cnt_sda + SCW'(1);
      end
      if (hit_c) begin
        stuck_o <= 1'b1;
      end
    end
  end

endmodule
